// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus arbiter: state encoding,
// a constant-friendly log2 helper and the default inactivity timeout.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

   localparam int DEFAULT_TIMEOUT = 256;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2_int(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational winner selection: first set request scanning upward from ptr
// with wrap-around, or from index 0 when rr_en is low (fixed priority).
module arb_rr_picker #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic           rr_en,
   output logic           valid,
   output logic [IDW-1:0] idx
);

   localparam int          W1    = IDW + 1;
   localparam logic [IDW:0] N_EXT = W1'(N);

   logic [IDW:0] base;
   logic [IDW:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      base  = '0;
      cand  = '0;
      // An out-of-range pointer falls back to index 0 so the wrap stays single-step.
      if (rr_en && ({1'b0, ptr} < N_EXT)) base = {1'b0, ptr};
      for (int i = 0; i < N; i++) begin
         cand = base + W1'(i);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!valid && req[cand[IDW-1:0]]) begin
            valid = 1'b1;
            idx   = cand[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: IDLE/OWNED/GAP FSM with round-robin or fixed priority,
// an inactivity timeout that forces release, and one idle slot between owners.
module bus_arbiter_n
   import bus_pkg::*;
#(
   parameter int  NUM_MASTERS = 4,
   parameter int  RR_MODE     = 1,
   parameter int  TIMEOUT     = DEFAULT_TIMEOUT,
   localparam int IDW         = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] breq,
   output logic [NUM_MASTERS-1:0] bgrant,
   input  logic                   bus_mvalid,
   input  logic                   bus_svalid,
   output logic [IDW-1:0]         owner,
   output logic                   bus_busy,
   output logic                   timeout,
   output logic [IDW-1:0]         timeout_id,
   output arb_state_e             state_dbg
);

   // Request/grant handshake: breq is a level a master holds for its whole
   // transaction; bgrant rises on the edge after breq is seen in IDLE and stays
   // until that master drops breq or the inactivity timeout fires.

   localparam int             CW       = clog2_int(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
   localparam logic [IDW-1:0] IDX_LAST = IDW'(NUM_MASTERS - 1);
   localparam logic           RR_EN    = (RR_MODE != 0);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
   logic [IDW-1:0]         owner_q, owner_d;
   logic                   busy_q, busy_d;
   logic                   timeout_q, timeout_d;
   logic [IDW-1:0]         timeout_id_q, timeout_id_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]          idle_cnt_q, idle_cnt_d;

   logic                   pick_valid;
   logic [IDW-1:0]         pick_idx;
   logic                   activity;

   arb_rr_picker #(
      .N   (NUM_MASTERS),
      .IDW (IDW)
   ) u_picker (
      .req   (breq),
      .ptr   (rr_ptr_q),
      .rr_en (RR_EN),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign activity = bus_mvalid | bus_svalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bgrant_q     <= '0;
         owner_q      <= '0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         timeout_id_q <= '0;
         rr_ptr_q     <= '0;
         idle_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         bgrant_q     <= bgrant_d;
         owner_q      <= owner_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
         timeout_id_q <= timeout_id_d;
         rr_ptr_q     <= rr_ptr_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bgrant_d     = bgrant_q;
      owner_d      = owner_q;
      busy_d       = busy_q;
      timeout_d    = 1'b0;
      timeout_id_d = timeout_id_q;
      rr_ptr_d     = rr_ptr_q;
      idle_cnt_d   = idle_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d    = ST_OWNED;
               bgrant_d   = NUM_MASTERS'(1) << pick_idx;
               owner_d    = pick_idx;
               busy_d     = 1'b1;
               idle_cnt_d = '0;
               if (RR_EN) rr_ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            end
         end

         ST_OWNED: begin
            // A voluntary drop wins over a timeout landing on the same edge.
            if (!breq[owner_q]) begin
               state_d  = ST_GAP;
               bgrant_d = '0;
               busy_d   = 1'b0;
            end else if (!activity && (idle_cnt_q == CNT_LAST)) begin
               state_d      = ST_GAP;
               bgrant_d     = '0;
               busy_d       = 1'b0;
               timeout_d    = 1'b1;
               timeout_id_d = owner_q;
            end else if (activity) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q != CNT_MAX) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d  = ST_IDLE;
            bgrant_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   assign bgrant     = bgrant_q;
   assign owner      = owner_q;
   assign bus_busy   = busy_q;
   assign timeout    = timeout_q;
   assign timeout_id = timeout_id_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: a round-robin and a fixed-priority instance share
// stimulus and are each checked every cycle against an abstract arbitration model.
module tb_bus_arbiter_n;
   import bus_pkg::*;

   localparam int NM = 4;
   localparam int TO = 8;

   logic          clk;
   logic          rst;
   logic [NM-1:0] breq;
   logic          mv;
   logic          sv;

   logic [NM-1:0] bgrant_rr, bgrant_fp;
   logic [1:0]    owner_rr, owner_fp;
   logic          busy_rr, busy_fp;
   logic          to_rr, to_fp;
   logic [1:0]    tid_rr, tid_fp;
   arb_state_e    st_rr, st_fp;

   int tests;
   int fails;

   typedef struct {
      int owner;   // -1 when the bus is free
      int idle;
      bit gap;     // release happened; one dead cycle before IDLE
      int ptr;
      bit to;
      int to_id;
   } mdl_t;

   mdl_t m_rr, m_fp;
   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];

   bus_arbiter_n #(.NUM_MASTERS(NM), .RR_MODE(1), .TIMEOUT(TO)) dut_rr (
      .clk(clk), .rst(rst), .breq(breq), .bgrant(bgrant_rr),
      .bus_mvalid(mv), .bus_svalid(sv), .owner(owner_rr), .bus_busy(busy_rr),
      .timeout(to_rr), .timeout_id(tid_rr), .state_dbg(st_rr)
   );

   bus_arbiter_n #(.NUM_MASTERS(NM), .RR_MODE(0), .TIMEOUT(TO)) dut_fp (
      .clk(clk), .rst(rst), .breq(breq), .bgrant(bgrant_fp),
      .bus_mvalid(mv), .bus_svalid(sv), .owner(owner_fp), .bus_busy(busy_fp),
      .timeout(to_fp), .timeout_id(tid_fp), .state_dbg(st_fp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.owner = -1; m.idle = 0; m.gap = 1'b0; m.ptr = 0; m.to = 1'b0; m.to_id = 0;
      return m;
   endfunction

   // One bus cycle of the arbitration rules, applied to the levels seen at the edge.
   function automatic mdl_t mdl_step(mdl_t m, logic [NM-1:0] req, bit act, bit rr);
      mdl_t n;
      int   rq;
      int   base;
      int   cand;
      bit   found;
      n = m;
      n.to = 1'b0;
      rq = int'(req);
      if (m.owner >= 0) begin
         if (((rq >> m.owner) & 1) == 0) begin
            n.owner = -1; n.gap = 1'b1;
         end else if (!act && m.idle == TO - 1) begin
            n.to = 1'b1; n.to_id = m.owner; n.owner = -1; n.gap = 1'b1;
         end else begin
            n.idle = act ? 0 : m.idle + 1;
         end
      end else if (m.gap) begin
         n.gap = 1'b0;
      end else if (rq != 0) begin
         base = rr ? m.ptr : 0;
         found = 1'b0;
         for (int k = 0; k < NM; k++) begin
            cand = (base + k) % NM;
            if (!found && ((rq >> cand) & 1) == 1) begin
               found = 1'b1;
               n.owner = cand;
            end
         end
         n.idle = 0;
         if (rr) n.ptr = (n.owner + 1) % NM;
      end
      return n;
   endfunction

   function automatic logic [NM-1:0] exp_grant(mdl_t m);
      return (m.owner >= 0) ? NM'(1 << m.owner) : '0;
   endfunction

   function automatic logic [3:0] idx_of(logic [NM-1:0] v);
      logic [3:0] r;
      r = 4'hf;
      for (int i = 0; i < NM; i++) if (v[i]) r = 4'(i);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string nm, input mdl_t m, input logic [NM-1:0] bg,
                            input logic bz, input logic [1:0] ow, input logic to,
                            input logic [1:0] tid);
      check({nm, ".bgrant"}, 32'(bg), 32'(exp_grant(m)));
      check({nm, ".onehot"}, 32'($onehot0(bg)), 32'd1);
      check({nm, ".busy"}, 32'(bz), 32'(m.owner >= 0));
      check({nm, ".timeout"}, 32'(to), 32'(m.to));
      check({nm, ".timeout_id"}, 32'(tid), 32'(m.to_id));
      if (m.owner >= 0) check({nm, ".owner"}, 32'(ow), 32'(m.owner));
   endtask

   // Inputs change at the falling edge; outputs are checked at the next falling edge.
   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         m_rr = mdl_reset();
         m_fp = mdl_reset();
      end else begin
         m_rr = mdl_step(m_rr, breq, mv | sv, 1'b1);
         m_fp = mdl_step(m_fp, breq, mv | sv, 1'b0);
      end
      @(negedge clk);
      check_dut("rr", m_rr, bgrant_rr, busy_rr, owner_rr, to_rr, tid_rr);
      check_dut("fp", m_fp, bgrant_fp, busy_fp, owner_fp, to_fp, tid_fp);
   endtask

   // Hold base_req; the tracked instance's owner drops its request after 3 owned cycles.
   task automatic run_hold(input logic [NM-1:0] base_req, input bit use_rr, input int n_cycles);
      int            held;
      int            own;
      logic [NM-1:0] prev;
      logic [NM-1:0] cur;
      held = 0;
      prev = use_rr ? bgrant_rr : bgrant_fp;
      for (int c = 0; c < n_cycles; c++) begin
         own = use_rr ? m_rr.owner : m_fp.owner;
         held = (own >= 0) ? held + 1 : 0;
         breq = base_req;
         if (own >= 0 && held >= 3) breq[own] = 1'b0;
         cycle();
         cur = use_rr ? bgrant_rr : bgrant_fp;
         if (prev == '0 && cur != '0) obs_q.push_back(idx_of(cur));
         prev = cur;
      end
   endtask

   task automatic compare_order(input string tag);
      check({tag, ".count"}, 32'(obs_q.size() >= exp_q.size()), 32'd1);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs_q.size()) check({tag, ".order"}, 32'(obs_q[i]), 32'(exp_q[i]));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      breq  = 4'b1111;
      mv    = 1'b0;
      sv    = 1'b0;
      m_rr  = mdl_reset();
      m_fp  = mdl_reset();
      @(negedge clk);

      // Reset held with every master requesting, then released.
      repeat (3) cycle();
      check("reset.bgrant", 32'(bgrant_rr), 32'd0);
      rst = 1'b0;
      cycle();
      check("release.grant0", 32'(bgrant_rr), 32'b0001);

      // Single requester, then drop and the dead slot.
      breq = 4'b0000;
      repeat (2) cycle();
      breq = 4'b0100;
      cycle();
      check("single.bgrant", 32'(bgrant_rr), 32'b0100);
      check("single.owner", 32'(owner_rr), 32'd2);
      breq = 4'b0000;
      cycle();
      check("single.drop", 32'(bgrant_rr), 32'd0);
      cycle();
      check("single.gap", 32'(busy_rr), 32'd0);

      // Round-robin fairness from a fresh pointer.
      breq = 4'b1111;
      reset_pulse();
      exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      run_hold(4'b1111, 1'b1, 34);
      compare_order("rr_fair");

      // Fixed priority: master 1 keeps winning over 2 and 3.
      exp_q = '{4'd1, 4'd1, 4'd1};
      run_hold(4'b1110, 1'b0, 24);
      compare_order("fp_starve");

      // Inactivity timeout on master 3.
      breq = 4'b1000;
      reset_pulse();
      for (int i = 0; i < 5 && bgrant_rr == '0; i++) cycle();
      n = 0;
      for (int i = 0; i < 30 && bgrant_rr != '0; i++) begin
         n++;
         cycle();
      end
      check("timeout.len", 32'(n), 32'(TO));
      check("timeout.pulse", 32'(to_rr), 32'd1);
      check("timeout.id", 32'(tid_rr), 32'd3);
      cycle();
      check("timeout.one_cycle", 32'(to_rr), 32'd0);

      // Master 3 re-competes; an mvalid pulse restarts the idle count.
      for (int i = 0; i < 5 && bgrant_rr == '0; i++) cycle();
      n = (bgrant_rr != '0) ? 1 : 0;
      repeat (4) begin
         cycle();
         if (bgrant_rr != '0) n++;
      end
      mv = 1'b1;
      cycle();
      if (bgrant_rr != '0) n++;
      mv = 1'b0;
      for (int i = 0; i < 30 && bgrant_rr != '0; i++) begin
         cycle();
         if (bgrant_rr != '0) n++;
      end
      check("timeout.restart_len", 32'(n), 32'(5 + TO));

      // Asynchronous reset while master 1 owns the bus.
      breq = 4'b0000;
      reset_pulse();
      breq = 4'b0010;
      for (int i = 0; i < 5 && bgrant_rr == '0; i++) cycle();
      check("midrst.owned", 32'(owner_rr), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst.async_rr", 32'(bgrant_rr), 32'd0);
      check("midrst.async_fp", 32'(bgrant_fp), 32'd0);
      check("midrst.busy", 32'(busy_rr), 32'd0);
      m_rr = mdl_reset();
      m_fp = mdl_reset();
      breq = 4'b0011;
      cycle();
      rst = 1'b0;
      cycle();
      check("midrst.ptr0", 32'(bgrant_rr), 32'b0001);

      // Random request levels and sparse bus activity.
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < NM; b++) if ($urandom_range(0, 3) == 0) breq[b] = ~breq[b];
         mv = ($urandom_range(0, 9) == 0);
         sv = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
